// File: rtl/sw_reg_pkg.sv
// Shared register map and field positions for the sw_reg Wishbone slaves.
package sw_reg_pkg;

    // Register select, taken from byte offset bits [3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS fields
    localparam int unsigned STATUS_NEW_BIT   = 0;
    localparam int unsigned STATUS_OVF_BIT   = 1;
    localparam int unsigned STATUS_COUNT_LSB = 16;

    // CTRL fields
    localparam int unsigned CTRL_CAPTURE_EN_BIT = 0;
    localparam int unsigned CTRL_INT_EN_BIT     = 1;
    localparam int unsigned CTRL_FREEZE_BIT     = 2;

    localparam int unsigned COUNT_WIDTH = 16;

endpackage

// File: rtl/wbs_ack_gen.sv
// Wishbone slave address decode with a registered single-cycle ack.
// xfer_o marks the one cycle per transfer in which register side effects apply;
// a held strobe gets an ack every other cycle.
module wbs_ack_gen #(
    parameter logic [31:0] DEV_BASE_ADDR  = 32'h0,
    parameter logic [31:0] DEV_HIGH_ADDR  = 32'h0F,
    parameter int unsigned BUS_ADDR_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
    output logic                      ack_o,
    output logic                      xfer_o,
    output logic [1:0]                reg_sel_o
);

    localparam logic [31:0] Span = DEV_HIGH_ADDR - DEV_BASE_ADDR;

    logic [31:0] adr_ext;
    logic [31:0] offset;
    logic        hit;
    logic        ack_q;
    logic        unused_offset;

    // An address below the base wraps to a huge offset, so one compare covers both bounds
    assign adr_ext       = 32'(wbs_adr_i);
    assign offset        = adr_ext - DEV_BASE_ADDR;
    assign hit           = wbs_cyc_i & wbs_stb_i & (offset <= Span);
    assign xfer_o        = hit & ~ack_q;
    assign ack_o         = ack_q;
    assign reg_sel_o     = offset[3:2];
    assign unused_offset = ^{offset[31:4], offset[1:0]};

    // Ack follows a fresh hit by one cycle, then drops for one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= xfer_o;
        end
    end

endmodule

// File: rtl/sw_reg_rd.sv
// Fabric-to-software status register: captures a fabric word and exposes it,
// with new/overflow flags, a capture counter, freeze and interrupt, over Wishbone.
module sw_reg_rd
    import sw_reg_pkg::*;
#(
    parameter logic [31:0] DEV_BASE_ADDR  = 32'h0,
    parameter logic [31:0] DEV_HIGH_ADDR  = 32'h0F,
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 8,
    parameter int unsigned BYTE_EN_WIDTH  = BUS_DATA_WIDTH / 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [BYTE_EN_WIDTH-1:0]  wbs_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0] wbs_dat_i,
    output logic [BUS_DATA_WIDTH-1:0] wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic                      wbs_int_o,
    input  logic [BUS_DATA_WIDTH-1:0] fabric_data_i,
    input  logic                      fabric_valid_i
);

    logic                      xfer;
    logic [1:0]                reg_sel;
    logic                      rd, wr, capture, status_wr, ctrl_wr, clr_new, clr_ovf;
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic [63:0]               status_word, ctrl_word;
    logic                      unused_bus;

    logic [BUS_DATA_WIDTH-1:0] data_q, data_d, dat_q, dat_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      new_q, new_d, ovf_q, ovf_d;
    logic                      cap_en_q, cap_en_d, int_en_q, int_en_d, freeze_q, freeze_d;
    logic                      int_q, int_d;

    wbs_ack_gen #(
        .DEV_BASE_ADDR  (DEV_BASE_ADDR),
        .DEV_HIGH_ADDR  (DEV_HIGH_ADDR),
        .BUS_ADDR_WIDTH (BUS_ADDR_WIDTH)
    ) u_ack_gen (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_adr_i (wbs_adr_i),
        .ack_o     (wbs_ack_o),
        .xfer_o    (xfer),
        .reg_sel_o (reg_sel)
    );

    assign rd         = xfer & ~wbs_we_i;
    assign wr         = xfer & wbs_we_i;
    assign capture    = fabric_valid_i & cap_en_q & ~freeze_q;
    assign status_wr  = wr & (reg_sel == REG_STATUS) & wbs_sel_i[0];
    assign ctrl_wr    = wr & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    assign clr_new    = (rd & (reg_sel == REG_DATA)) | (status_wr & wbs_dat_i[STATUS_NEW_BIT]);
    assign clr_ovf    = status_wr & wbs_dat_i[STATUS_OVF_BIT];
    assign unused_bus = ^{wbs_sel_i, wbs_dat_i};

    assign wbs_dat_o = dat_q;
    assign wbs_int_o = int_q;

    // Read mux; words are built 64 bits wide and truncated to the bus width
    always_comb begin
        status_word = '0;
        status_word[STATUS_NEW_BIT] = new_q;
        status_word[STATUS_OVF_BIT] = ovf_q;
        status_word[STATUS_COUNT_LSB +: COUNT_WIDTH] = count_q;
        ctrl_word = '0;
        ctrl_word[CTRL_CAPTURE_EN_BIT] = cap_en_q;
        ctrl_word[CTRL_INT_EN_BIT]     = int_en_q;
        ctrl_word[CTRL_FREEZE_BIT]     = freeze_q;
        rdata = '0;
        unique case (reg_sel)
            REG_DATA:   rdata = data_q;
            REG_STATUS: rdata = status_word[BUS_DATA_WIDTH-1:0];
            REG_CTRL:   rdata = ctrl_word[BUS_DATA_WIDTH-1:0];
            default:    rdata = '0;
        endcase
    end

    // Next state: capture sets win over software clears arriving on the same edge
    always_comb begin
        data_d   = data_q;
        count_d  = count_q;
        new_d    = new_q;
        ovf_d    = ovf_q;
        cap_en_d = cap_en_q;
        int_en_d = int_en_q;
        freeze_d = freeze_q;
        if (clr_new) new_d = 1'b0;
        if (clr_ovf) ovf_d = 1'b0;
        if (capture) begin
            data_d  = fabric_data_i;
            count_d = count_q + COUNT_WIDTH'(1);
            new_d   = 1'b1;
            if (new_q & ~clr_new) ovf_d = 1'b1;
        end
        if (ctrl_wr) begin
            cap_en_d = wbs_dat_i[CTRL_CAPTURE_EN_BIT];
            int_en_d = wbs_dat_i[CTRL_INT_EN_BIT];
            freeze_d = wbs_dat_i[CTRL_FREEZE_BIT];
        end
        dat_d = rd ? rdata : '0;
        int_d = int_en_q & (new_q | ovf_q);
    end

    // State registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            data_q   <= '0;
            count_q  <= '0;
            new_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cap_en_q <= 1'b1;
            int_en_q <= 1'b0;
            freeze_q <= 1'b0;
            dat_q    <= '0;
            int_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            count_q  <= count_d;
            new_q    <= new_d;
            ovf_q    <= ovf_d;
            cap_en_q <= cap_en_d;
            int_en_q <= int_en_d;
            freeze_q <= freeze_d;
            dat_q    <= dat_d;
            int_q    <= int_d;
        end
    end

endmodule

// File: tb/tb_sw_reg_rd.sv
// Self-checking bench for sw_reg_rd against a register-level behavioural model.
module tb_sw_reg_rd;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [7:0]  adr = 8'h0;
    logic [31:0] wdat = 32'h0, rdat;
    logic        ack, irq;
    logic [31:0] fdata = 32'h0;
    logic        fvalid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_data;
    bit          m_new, m_ovf, m_cap_en, m_int_en, m_freeze;
    int unsigned m_count;

    sw_reg_rd dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_cyc_i      (cyc),
        .wbs_stb_i      (stb),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (wdat),
        .wbs_dat_o      (rdat),
        .wbs_ack_o      (ack),
        .wbs_int_o      (irq),
        .fabric_data_i  (fdata),
        .fabric_valid_i (fvalid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = 0; m_new = 0; m_ovf = 0; m_count = 0;
        m_cap_en = 1; m_int_en = 0; m_freeze = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a[3:2])
            2'd0:    return m_data;
            2'd1:    return (m_count << 16) | (32'(m_ovf) << 1) | 32'(m_new);
            2'd2:    return (32'(m_freeze) << 2) | (32'(m_int_en) << 1) | 32'(m_cap_en);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_irq();
        return m_int_en && (m_new || m_ovf);
    endfunction

    // One clock edge of the register file: optional bus access plus optional fabric word
    task automatic model_step(input bit acc, input bit w, input logic [7:0] a,
                              input logic [31:0] wd, input logic [3:0] sl,
                              input bit cap, input logic [31:0] cd);
        bit is_data, is_status, is_ctrl, clr_new, clr_ovf, took, old_new;
        is_data   = acc && a[3:2] == 2'd0;
        is_status = acc && a[3:2] == 2'd1;
        is_ctrl   = acc && a[3:2] == 2'd2;
        clr_new   = (is_data && !w) || (is_status && w && sl[0] && wd[0]);
        clr_ovf   = is_status && w && sl[0] && wd[1];
        took      = cap && m_cap_en && !m_freeze;
        old_new   = m_new;
        if (clr_new) m_new = 0;
        if (clr_ovf) m_ovf = 0;
        if (took) begin
            m_data  = cd;
            m_count = (m_count + 1) % 65536;
            m_new   = 1;
            if (old_new && !clr_new) m_ovf = 1;
        end
        if (is_ctrl && w && sl[0]) begin
            m_cap_en = wd[0]; m_int_en = wd[1]; m_freeze = wd[2];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; cyc = 0; stb = 0; we = 0; fvalid = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // Single bus transfer; lat is the number of cycles until ack, or -1 on timeout
    task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] sl, input bit cap, input logic [31:0] cd,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = wd; sel = sl;
        fvalid = cap; fdata = cd;
        lat = -1; rd = 32'hx;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            fvalid = 0;
            if (ack) begin
                lat = k; rd = rdat;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic capture(input logic [31:0] d);
        @(negedge clk);
        fvalid = 1; fdata = d;
        @(negedge clk);
        fvalid = 0;
        model_step(0, 0, 8'h0, 32'h0, 4'h0, 1, d);
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        logic [7:0]  addrs [3] = '{8'h0, 8'h4, 8'h8};
        int lat;
        do_reset();
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
        n_checks++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", rdat); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b want 0", irq); end
        foreach (addrs[i]) begin
            exp = model_read(addrs[i]);
            bus(0, addrs[i], 32'h0, 4'hF, 0, 32'h0, rd, lat);
            model_step(1, 0, addrs[i], 32'h0, 4'hF, 0, 32'h0);
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL reset_rd_lat adr %h got %0d want 1", addrs[i], lat); end
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL reset_rd adr %h got %h want %h", addrs[i], rd, exp); end
        end
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl got %h want 1", rd); end
    endtask

    task automatic test_capture_read();
        logic [31:0] rd, exp;
        logic [7:0]  addrs [3] = '{8'h4, 8'h0, 8'h4};
        logic [31:0] want  [3] = '{32'h00010001, 32'hDEADBEEF, 32'h00010000};
        int lat;
        do_reset();
        capture(32'hDEADBEEF);
        foreach (addrs[i]) begin
            exp = model_read(addrs[i]);
            bus(0, addrs[i], 32'h0, 4'hF, 0, 32'h0, rd, lat);
            model_step(1, 0, addrs[i], 32'h0, 4'hF, 0, 32'h0);
            n_checks++;
            if (lat != 1 || rd !== exp || rd !== want[i]) begin
                n_fail++;
                $display("FAIL capture_read adr %h got %h lat %0d want %h", addrs[i], rd, lat, want[i]);
            end
        end
    endtask

    task automatic test_overflow_w1c();
        logic [31:0] rd, exp;
        int lat;
        do_reset();
        capture(32'h1);
        capture(32'h2);
        exp = model_read(8'h4);
        bus(0, 8'h4, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h4, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL ovf_status got %h want %h", rd, exp); end
        bus(1, 8'h4, 32'h2, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 1, 8'h4, 32'h2, 4'hF, 0, 32'h0);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ovf_w1c_ack got %0d want 1", lat); end
        exp = model_read(8'h4);
        bus(0, 8'h4, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h4, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL ovf_after_w1c got %h want %h", rd, exp); end
        exp = model_read(8'h0);
        bus(0, 8'h0, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h0, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL ovf_data got %h want %h", rd, exp); end
    endtask

    task automatic test_freeze_int();
        logic [31:0] rd, exp;
        int lat;
        bit seen;
        do_reset();
        bus(1, 8'h8, 32'h6, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 1, 8'h8, 32'h6, 4'hF, 0, 32'h0);
        capture(32'h55);
        exp = model_read(8'h0);
        bus(0, 8'h0, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h0, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL frozen_data got %h want %h", rd, exp); end
        exp = model_read(8'h4);
        bus(0, 8'h4, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h4, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL frozen_status got %h want %h", rd, exp); end
        bus(1, 8'h8, 32'h3, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 1, 8'h8, 32'h3, 4'hF, 0, 32'h0);
        capture(32'hA5A5A5A5);
        seen = 0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            seen = (irq === 1'b1);
        end
        n_checks++; if (seen != model_irq()) begin n_fail++; $display("FAIL int_rise got %b want %b", seen, model_irq()); end
        bus(0, 8'h0, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h0, 32'h0, 4'hF, 0, 32'h0);
        for (int k = 0; k < 2 && irq !== 1'b0; k++) @(negedge clk);
        n_checks++; if (irq !== 1'(model_irq())) begin n_fail++; $display("FAIL int_fall got %b want %b", irq, model_irq()); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd, exp;
        int lat;
        do_reset();
        capture(32'h11111111);
        exp = model_read(8'h0);
        bus(0, 8'h0, 32'h0, 4'hF, 1, 32'h22222222, rd, lat);
        model_step(1, 0, 8'h0, 32'h0, 4'hF, 1, 32'h22222222);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL simul_data got %h want %h", rd, exp); end
        exp = model_read(8'h4);
        bus(0, 8'h4, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h4, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL simul_status got %h want %h", rd, exp); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, wd, cd;
        logic [7:0]  a;
        logic [3:0]  sl;
        int lat, op;
        bit w, cap;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 4);
            a  = 8'($urandom_range(0, 3) * 4);
            sl = 4'($urandom);
            cd = $urandom;
            if (op == 0) begin
                capture(cd);
            end else begin
                w   = (op == 2 || op == 3);
                cap = (op == 4 || (op == 3 && $urandom_range(0, 1) == 1));
                wd  = $urandom;
                if (op == 2) begin
                    a  = 8'h8;
                    wd = {29'h0, ($urandom_range(0, 3) == 0), 2'($urandom)};
                end
                exp = w ? 32'h0 : model_read(a);
                bus(w, a, wd, sl, cap, cd, rd, lat);
                model_step(1, w, a, wd, sl, cap, cd);
                n_checks++;
                if (lat != 1 || rd !== exp) begin
                    n_fail++;
                    $display("FAIL rand_bus it %0d we %0b adr %h got %h lat %0d want %h", it, w, a, rd, lat, exp);
                end
            end
            repeat (2) @(negedge clk);
            n_checks++;
            if (irq !== 1'(model_irq())) begin
                n_fail++;
                $display("FAIL rand_int it %0d got %b want %b", it, irq, model_irq());
            end
        end
    endtask

    task automatic test_miss();
        do_reset();
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 8'h10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL miss_ack cycle %0d got %b want 0", k, ack); end
        end
        cyc = 0; stb = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] rd, exp;
        int lat;
        do_reset();
        @(negedge clk);
        fvalid = 1; fdata = 32'hCAFE0000;
        repeat (65536) @(negedge clk);
        fvalid = 0;
        for (int i = 0; i < 65536; i++) model_step(0, 0, 8'h0, 32'h0, 4'h0, 1, 32'hCAFE0000);
        exp = model_read(8'h4);
        bus(0, 8'h4, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h4, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL wrap_status got %h want %h", rd, exp); end
        n_checks++; if (rd[31:16] !== 16'h0) begin n_fail++; $display("FAIL wrap_count got %h want 0", rd[31:16]); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd, exp;
        int lat;
        do_reset();
        capture(32'h12345678);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 8'h0;
        @(negedge clk);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_ack got %b want 1", ack); end
        #1 rst = 1;
        #1;
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack got %b want 0", ack); end
        n_checks++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL midrst_dat got %h want 0", rdat); end
        @(negedge clk);
        cyc = 0; stb = 0; rst = 0;
        model_reset();
        exp = model_read(8'h0);
        bus(0, 8'h0, 32'h0, 4'hF, 0, 32'h0, rd, lat);
        model_step(1, 0, 8'h0, 32'h0, 4'hF, 0, 32'h0);
        n_checks++; if (lat != 1 || rd !== exp) begin n_fail++; $display("FAIL midrst_reread got %h lat %0d want %h", rd, lat, exp); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_capture_read();
        test_overflow_w1c();
        test_freeze_int();
        test_simultaneous();
        test_random();
        test_miss();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
